// File: rtl/fft_pkg.sv
// Shared types, default sizing and butterfly address generation for the
// radix-2 DIF stage scheduler.
package fft_pkg;

    localparam int DEF_LOG2N   = 10;
    localparam int DEF_MEM_LAT = 1;
    localparam int DEF_PE_LAT  = 3;
    localparam int N           = 1 << DEF_LOG2N;
    localparam int L           = DEF_MEM_LAT + DEF_PE_LAT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] tf;
    } bfly_t;

    // Butterfly k of stage s: operand pair (a, a+span) and twiddle exponent.
    function automatic bfly_t bfly_addr(input int log2n, input int s, input int k);
        bfly_t r;
        int    span;
        int    lo;
        span = 1 << (log2n - 1 - s);
        lo   = k & (span - 1);
        r.a  = ((k >> (log2n - 1 - s)) << (log2n - s)) | lo;
        r.b  = r.a + span;
        r.tf = lo << s;
        return r;
    endfunction

endpackage

// File: rtl/sched_delay.sv
// Fixed-depth shift register with synchronous active-low clear; aligns
// issue-time information with later pipeline stages.
module sched_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= RST_VAL;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/fft_stage_sched.sv
// Issues butterfly read/twiddle addresses for every DIF stage of an in-place
// FFT and aligns write-back and bypass_n with the PE pipeline.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | one butterfly per non-held cycle, k = 0 .. N/2-1
// DRAIN | L cycles so the stage's last write lands before the next stage reads
// FIN   | done pulse, back to IDLE
module fft_stage_sched
    import fft_pkg::*;
#(
    parameter int LOG2N   = DEF_LOG2N,
    parameter int MEM_LAT = DEF_MEM_LAT,
    parameter int PE_LAT  = DEF_PE_LAT
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    start,
    input  logic                    hold,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(LOG2N):0]  stage,
    output logic                    rd_en,
    output logic [LOG2N-1:0]        rd_addr_a,
    output logic [LOG2N-1:0]        rd_addr_b,
    output logic [LOG2N-2:0]        tf_addr,
    output logic                    bypass_n,
    output logic                    wr_en,
    output logic [LOG2N-1:0]        wr_addr_a,
    output logic [LOG2N-1:0]        wr_addr_b
);

    localparam int LAT       = MEM_LAT + PE_LAT;
    localparam int KW        = LOG2N - 1;
    localparam int SW        = $clog2(LOG2N) + 1;
    localparam int CW        = $clog2(LAT + 1);
    localparam int BYP_DEPTH = MEM_LAT + 2;
    localparam int DW        = 1 + 2 * LOG2N;

    localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
    localparam logic [KW-1:0] K_LAST = '1;

    state_t        state, state_nx;
    logic [KW-1:0] k, k_nx;
    logic [SW-1:0] s, s_nx;
    logic [CW-1:0] cnt, cnt_nx;

    bfly_t         bf;
    logic          byp_issue;
    logic          byp_hold;
    logic [DW-1:0] wr_word;
    logic [1:0]    byp_word;
    logic          unused_bf_bits;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= IDLE;
            k     <= '0;
            s     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            k     <= k_nx;
            s     <= s_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        k_nx     = k;
        s_nx     = s;
        cnt_nx   = cnt;
        rd_en    = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = ISSUE;
                    s_nx     = '0;
                    k_nx     = '0;
                end
            end
            ISSUE: begin
                if (!hold) begin
                    rd_en = 1'b1;
                    k_nx  = k + KW'(1);
                    if (k == K_LAST) begin
                        state_nx = DRAIN;
                        cnt_nx   = CW'(LAT - 1);
                    end
                end
            end
            DRAIN: begin
                if (cnt == '0) begin
                    if (s == S_LAST) begin
                        state_nx = FIN;
                    end else begin
                        state_nx = ISSUE;
                        s_nx     = s + SW'(1);
                        k_nx     = '0;
                    end
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
                s_nx     = '0;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb bf = bfly_addr(LOG2N, int'(s), int'(k));

    // Addresses are forced to zero off-issue so the delay line carries clean bubbles.
    assign rd_addr_a = rd_en ? bf.a[LOG2N-1:0]  : '0;
    assign rd_addr_b = rd_en ? bf.b[LOG2N-1:0]  : '0;
    assign tf_addr   = rd_en ? bf.tf[LOG2N-2:0] : '0;
    assign unused_bf_bits = ^{bf.a[31:LOG2N], bf.b[31:LOG2N], bf.tf[31:LOG2N-1]};

    assign busy      = (state != IDLE);
    assign stage     = s;
    assign byp_issue = (s != S_LAST);

    sched_delay #(
        .WIDTH   (DW),
        .DEPTH   (LAT),
        .RST_VAL ('0)
    ) u_wr_dly (
        .clk     (Clk),
        .reset_n (Reset_n),
        .din     ({rd_en, rd_addr_a, rd_addr_b}),
        .dout    (wr_word)
    );

    assign {wr_en, wr_addr_a, wr_addr_b} = wr_word;

    sched_delay #(
        .WIDTH   (2),
        .DEPTH   (BYP_DEPTH),
        .RST_VAL (2'b01)
    ) u_byp_dly (
        .clk     (Clk),
        .reset_n (Reset_n),
        .din     ({rd_en, byp_issue}),
        .dout    (byp_word)
    );

    // Last delivered bypass value is kept across hold bubbles and idle gaps.
    always_ff @(posedge Clk) begin
        if (!Reset_n)        byp_hold <= 1'b1;
        else if (byp_word[1]) byp_hold <= byp_word[0];
    end

    assign bypass_n = byp_word[1] ? byp_word[0] : byp_hold;

endmodule
